// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: serve/rally/point/game-over flow, score registers and LED drive.
// Optional build macro PONG_LED_SCORE_EN shows the scores on the LEDs instead of the state.
module pong_match_ctrl #(
   parameter int SCORE_W      = 4,
   parameter int WIN_SCORE    = 7,
   parameter int SERVE_FRAMES = 60,
   parameter int POINT_FRAMES = 90,
   parameter int LEDS_W       = 4
) (
   input  logic               clk_i,
   input  logic               rst_n_i,
   input  logic               frame_i,
   input  logic               start_i,
   input  logic               miss_l_i,
   input  logic               miss_r_i,
   output logic               ball_rst_o,
   output logic               ball_en_o,
   output logic               serve_dir_o,
   output logic [SCORE_W-1:0] score_l_o,
   output logic [SCORE_W-1:0] score_r_o,
   output logic [1:0]         winner_o,
   output logic [2:0]         state_o,
   output logic [LEDS_W-1:0]  leds_o
);

   // Zero-valued parameters behave as 1.
   localparam int SF_I   = (SERVE_FRAMES < 1) ? 1 : SERVE_FRAMES;
   localparam int PF_I   = (POINT_FRAMES < 1) ? 1 : POINT_FRAMES;
   localparam int WIN_I  = (WIN_SCORE < 1) ? 1 : WIN_SCORE;
   localparam int MAXF   = (SF_I > PF_I) ? SF_I : PF_I;
   localparam int CNT_W  = $clog2(MAXF + 1);
   localparam logic [CNT_W-1:0]   SERVE_LD = CNT_W'(SF_I);
   localparam logic [CNT_W-1:0]   POINT_LD = CNT_W'(PF_I);
   localparam logic [SCORE_W-1:0] WIN_EFF  = SCORE_W'(WIN_I);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SERVE = 3'd1,
      S_PLAY  = 3'd2,
      S_POINT = 3'd3,
      S_OVER  = 3'd4
   } state_t;

   // Assertion is immediate; release is seen by the FSM only after two clock edges.
   logic [1:0] rst_sync;
   logic       rst_n_int;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) rst_sync <= 2'b00;
      else          rst_sync <= {rst_sync[0], 1'b1};
   end

   assign rst_n_int = rst_sync[1];

   state_t               state, state_n;
   logic [CNT_W-1:0]     cnt, cnt_n;
   logic [SCORE_W-1:0]   score_l, score_r, score_l_n, score_r_n;
   logic                 serve_dir, serve_dir_n;
   logic [1:0]           winner, winner_n;
   logic [LEDS_W-1:0]    leds_n;

   function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
      return (s >= WIN_EFF) ? s : s + 1'b1;
   endfunction

   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      score_l_n   = score_l;
      score_r_n   = score_r;
      serve_dir_n = serve_dir;
      winner_n    = winner;
      case (state)
         S_IDLE: begin
            if (start_i) begin
               state_n = S_SERVE;
               cnt_n   = SERVE_LD;
            end
         end
         S_SERVE: begin
            if (frame_i) begin
               if (cnt <= CNT_W'(1)) state_n = S_PLAY;
               else                  cnt_n   = cnt - 1'b1;
            end
         end
         S_PLAY: begin
            if (miss_l_i || miss_r_i) begin
               state_n = S_POINT;
               cnt_n   = POINT_LD;
               // A double miss is a void rally: nobody scores, serve side kept.
               if (miss_r_i && !miss_l_i) begin
                  score_l_n   = sat_inc(score_l);
                  serve_dir_n = 1'b1;
               end else if (miss_l_i && !miss_r_i) begin
                  score_r_n   = sat_inc(score_r);
                  serve_dir_n = 1'b0;
               end
            end
         end
         S_POINT: begin
            if (frame_i) begin
               if (cnt <= CNT_W'(1)) begin
                  if (score_l == WIN_EFF || score_r == WIN_EFF) begin
                     state_n  = S_OVER;
                     winner_n = (score_l == WIN_EFF) ? 2'b01 : 2'b10;
                  end else begin
                     state_n = S_SERVE;
                     cnt_n   = SERVE_LD;
                  end
               end else begin
                  cnt_n = cnt - 1'b1;
               end
            end
         end
         S_OVER: begin
            if (start_i) begin
               state_n     = S_SERVE;
               cnt_n       = SERVE_LD;
               score_l_n   = '0;
               score_r_n   = '0;
               winner_n    = 2'b00;
               serve_dir_n = 1'b1;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

`ifdef PONG_LED_SCORE_EN
   localparam int HI_W = LEDS_W - LEDS_W / 2;
   localparam int LO_W = LEDS_W / 2;
   logic [LEDS_W+SCORE_W-1:0] sl_ext, sr_ext;

   always_comb begin
      sl_ext = {{LEDS_W{1'b0}}, score_l_n};
      sr_ext = {{LEDS_W{1'b0}}, score_r_n};
      leds_n = {sl_ext[HI_W-1:0], sr_ext[LO_W-1:0]};
   end
`else
   always_comb begin
      leds_n    = '0;
      leds_n[0] = (state_n == S_PLAY);
      leds_n[1] = (state_n == S_SERVE);
      leds_n[2] = (state_n == S_POINT);
      leds_n[3] = (state_n == S_OVER);
   end
`endif

   always_ff @(posedge clk_i or negedge rst_n_int) begin
      if (!rst_n_int) begin
         state      <= S_IDLE;
         cnt        <= '0;
         score_l    <= '0;
         score_r    <= '0;
         serve_dir  <= 1'b1;
         winner     <= 2'b00;
         ball_rst_o <= 1'b1;
         ball_en_o  <= 1'b0;
         leds_o     <= '0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         score_l    <= score_l_n;
         score_r    <= score_r_n;
         serve_dir  <= serve_dir_n;
         winner     <= winner_n;
         ball_rst_o <= (state_n != S_PLAY);
         ball_en_o  <= (state_n == S_PLAY);
         leds_o     <= leds_n;
      end
   end

   assign state_o     = state;
   assign score_l_o   = score_l;
   assign score_r_o   = score_r;
   assign serve_dir_o = serve_dir;
   assign winner_o    = winner;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Bench for pong_match_ctrl: directed walk through the match flow, then random play
// checked every cycle against a frame-counting reference of the match rules.
module tb_pong_match_ctrl;

   localparam int SW  = 4;
   localparam int WIN = 2;
   localparam int SF  = 3;
   localparam int PF  = 2;
   localparam int LW  = 4;

   logic          clk_i = 1'b0;
   logic          rst_n_i = 1'b0;
   logic          frame_i = 1'b0, start_i = 1'b0, miss_l_i = 1'b0, miss_r_i = 1'b0;
   logic          ball_rst_o, ball_en_o, serve_dir_o;
   logic [SW-1:0] score_l_o, score_r_o;
   logic [1:0]    winner_o;
   logic [2:0]    state_o;
   logic [LW-1:0] leds_o;

   always #5 clk_i = ~clk_i;

   pong_match_ctrl #(
      .SCORE_W(SW), .WIN_SCORE(WIN), .SERVE_FRAMES(SF), .POINT_FRAMES(PF), .LEDS_W(LW)
   ) dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .frame_i(frame_i), .start_i(start_i),
      .miss_l_i(miss_l_i), .miss_r_i(miss_r_i), .ball_rst_o(ball_rst_o),
      .ball_en_o(ball_en_o), .serve_dir_o(serve_dir_o), .score_l_o(score_l_o),
      .score_r_o(score_r_o), .winner_o(winner_o), .state_o(state_o), .leds_o(leds_o)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Reference: phase 0 idle, 1 serve, 2 play, 3 point, 4 over; frames counted up from entry.
   int m_phase, m_frames, m_sl, m_sr, m_dir, m_win, m_hold;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_phase = 0; m_frames = 0; m_sl = 0; m_sr = 0; m_dir = 1; m_win = 0; m_hold = 0;
   endtask

   task automatic model_step(input logic st, input logic fr, input logic ml, input logic mr);
      if (m_hold < 2) begin
         m_hold++;
         return;
      end
      case (m_phase)
         0: if (st) begin m_phase = 1; m_frames = 0; end
         1: if (fr) begin
               m_frames++;
               if (m_frames == SF) m_phase = 2;
            end
         2: if (ml || mr) begin
               if (mr && !ml) begin m_sl = (m_sl + 1 > WIN) ? WIN : m_sl + 1; m_dir = 1; end
               if (ml && !mr) begin m_sr = (m_sr + 1 > WIN) ? WIN : m_sr + 1; m_dir = 0; end
               m_phase = 3; m_frames = 0;
            end
         3: if (fr) begin
               m_frames++;
               if (m_frames == PF) begin
                  if (m_sl == WIN || m_sr == WIN) begin
                     m_phase = 4;
                     m_win = (m_sl == WIN) ? 1 : 2;
                  end else begin
                     m_phase = 1; m_frames = 0;
                  end
               end
            end
         4: if (st) begin
               m_phase = 1; m_frames = 0; m_sl = 0; m_sr = 0; m_win = 0; m_dir = 1;
            end
         default: m_phase = 0;
      endcase
   endtask

   function automatic logic [31:0] exp_leds();
      int sl, sr;
      sl = m_sl; sr = m_sr;
`ifdef PONG_LED_SCORE_EN
      return {28'd0, sl[1:0], sr[1:0]};
`else
      case (m_phase)
         1: return 32'b0010;
         2: return 32'b0001;
         3: return 32'b0100;
         4: return 32'b1000;
         default: return 32'b0000;
      endcase
`endif
   endfunction

   task automatic compare_all();
      chk("state", {29'd0, state_o}, m_phase);
      chk("ball_en", {31'd0, ball_en_o}, (m_phase == 2) ? 1 : 0);
      chk("ball_rst", {31'd0, ball_rst_o}, (m_phase == 2) ? 0 : 1);
      chk("serve_dir", {31'd0, serve_dir_o}, m_dir);
      chk("score_l", {28'd0, score_l_o}, m_sl);
      chk("score_r", {28'd0, score_r_o}, m_sr);
      chk("winner", {30'd0, winner_o}, m_win);
      chk("leds", {28'd0, leds_o}, exp_leds());
   endtask

   // Compare process: model advances on the same edge as the DUT, outputs checked 1 time unit later.
   initial model_reset();
   always @(posedge clk_i) begin
      if (!rst_n_i) model_reset();
      else          model_step(start_i, frame_i, miss_l_i, miss_r_i);
      #1;
      compare_all();
   end

   task automatic drive(input logic st, input logic fr, input logic ml, input logic mr);
      start_i = st; frame_i = fr; miss_l_i = ml; miss_r_i = mr;
      @(negedge clk_i);
      start_i = 1'b0; frame_i = 1'b0; miss_l_i = 1'b0; miss_r_i = 1'b0;
   endtask

   task automatic frames(input int n);
      for (int k = 0; k < n; k++) drive(1'b0, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_state"}, {29'd0, state_o}, 0);
      chk({tag, "_ball_rst"}, {31'd0, ball_rst_o}, 1);
      chk({tag, "_ball_en"}, {31'd0, ball_en_o}, 0);
      chk({tag, "_dir"}, {31'd0, serve_dir_o}, 1);
      chk({tag, "_score_l"}, {28'd0, score_l_o}, 0);
      chk({tag, "_score_r"}, {28'd0, score_r_o}, 0);
      chk({tag, "_winner"}, {30'd0, winner_o}, 0);
      chk({tag, "_leds"}, {28'd0, leds_o}, 0);
   endtask

   task automatic async_reset(input string tag);
      @(negedge clk_i);
      #2 rst_n_i = 1'b0;
      #1 chk_reset_vals(tag);
      @(negedge clk_i);
      @(negedge clk_i);
      rst_n_i = 1'b1;
   endtask

   initial begin
      repeat (3) @(negedge clk_i);
      chk_reset_vals("por");
      rst_n_i = 1'b1;
      repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0);
      chk("idle_after_release", {29'd0, state_o}, 0);

      drive(1'b1, 1'b0, 1'b0, 1'b0);
      chk("start_to_serve", {29'd0, state_o}, 1);
      frames(2);
      chk("two_frames_en", {31'd0, ball_en_o}, 0);
      chk("two_frames_state", {29'd0, state_o}, 1);
      frames(1);
      chk("third_frame_en", {31'd0, ball_en_o}, 1);
      chk("third_frame_state", {29'd0, state_o}, 2);

      drive(1'b1, 1'b0, 1'b0, 1'b0);
      chk("start_in_play", {29'd0, state_o}, 2);

      drive(1'b0, 1'b0, 1'b0, 1'b1);
      chk("miss_r_score_l", {28'd0, score_l_o}, 1);
      chk("miss_r_en", {31'd0, ball_en_o}, 0);
      chk("miss_r_dir", {31'd0, serve_dir_o}, 1);
      chk("miss_r_state", {29'd0, state_o}, 3);
      frames(1);
      chk("point_one_frame", {29'd0, state_o}, 3);
      frames(1);
      chk("point_to_serve", {29'd0, state_o}, 1);

      drive(1'b0, 1'b0, 1'b1, 1'b1);
      chk("serve_miss_state", {29'd0, state_o}, 1);
      chk("serve_miss_score_l", {28'd0, score_l_o}, 1);
      chk("serve_miss_score_r", {28'd0, score_r_o}, 0);
      frames(3);

      drive(1'b0, 1'b0, 1'b1, 1'b1);
      chk("dbl_state", {29'd0, state_o}, 3);
      chk("dbl_score_l", {28'd0, score_l_o}, 1);
      chk("dbl_score_r", {28'd0, score_r_o}, 0);
      chk("dbl_dir", {31'd0, serve_dir_o}, 1);
      frames(2);
      frames(3);

      drive(1'b0, 1'b0, 1'b0, 1'b1);
      frames(2);
      chk("win_state", {29'd0, state_o}, 4);
      chk("win_winner", {30'd0, winner_o}, 1);
      chk("win_score_l", {28'd0, score_l_o}, 2);
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      chk("restart_state", {29'd0, state_o}, 1);
      chk("restart_score_l", {28'd0, score_l_o}, 0);
      chk("restart_winner", {30'd0, winner_o}, 0);

      frames(3);
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      chk("miss_l_dir", {31'd0, serve_dir_o}, 0);
      frames(2);
      frames(3);
      chk("pre_reset_state", {29'd0, state_o}, 2);
      chk("pre_reset_score_r", {28'd0, score_r_o}, 1);
      async_reset("mid_play");
      repeat (4) drive(1'b0, 1'b0, 1'b0, 1'b0);
      chk("post_reset_idle", {29'd0, state_o}, 0);

      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) async_reset("random");
         drive($urandom_range(0, 15) == 0, $urandom_range(0, 2) == 0,
               $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pong_match_ctrl.md
# pong_match_ctrl

Match sequencer for the pong game: owns the serve / rally / point / game-over flow and the score registers. It sits in `game_top` between the debounced key inputs and the ball/paddle datapath:
- gates ball motion (`ball_en_o`) and ball recentring (`ball_rst_o`);
- counts frame pulses for the serve and point pauses;
- updates scores from wall-miss events;
- drives the board LEDs.

## Interface
- `SCORE_W`, default 4: score register width.
- `WIN_SCORE`, default 7: points needed to win; must be at most 2^SCORE_W-1.
- `SERVE_FRAMES`, default 60: frames the ball is held before the rally starts.
- `POINT_FRAMES`, default 90: frames of pause after a point.
- `LEDS_W`, default 4: LED count; must be at least 4.

Ports:
- `clk_i` in 1: the single clock.
- `rst_n_i` in 1: reset, asynchronous, active-low.
- `frame_i` in 1: one-cycle pulse per video frame.
- `start_i` in 1: one-cycle start request from a debounced key.
- `miss_l_i` in 1: one-cycle pulse; ball passed the left wall.
- `miss_r_i` in 1: one-cycle pulse; ball passed the right wall.
- `ball_rst_o` out 1: holds the ball at centre.
- `ball_en_o` out 1: enables ball motion.
- `serve_dir_o` out 1: serve direction; 0 = toward left, 1 = toward right.
- `score_l_o` out `SCORE_W`: left player score.
- `score_r_o` out `SCORE_W`: right player score.
- `winner_o` out 2: 00 none, 01 left, 10 right.
- `state_o` out 3: current state encoding.
- `leds_o` out `LEDS_W`: LED drive, active-high.

## Operation
- States and encodings: IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4.
- IDLE: `ball_rst_o`=1, `ball_en_o`=0.
  - `start_i` → SERVE.
- SERVE: `ball_rst_o`=1, `ball_en_o`=0.
  - Frame counter is loaded with `SERVE_FRAMES` on entry.
  - Counter decrements on each `frame_i`.
  - `frame_i` with counter==1 → PLAY.
- PLAY: `ball_rst_o`=0, `ball_en_o`=1.
  - `miss_r_i` alone: `score_l` += 1, `serve_dir_o` := 1 → POINT.
  - `miss_l_i` alone: `score_r` += 1, `serve_dir_o` := 0 → POINT.
  - Both misses in the same cycle: no score change, `serve_dir_o` unchanged → POINT.
- POINT: `ball_en_o`=0, `ball_rst_o`=1.
  - Counter is loaded with `POINT_FRAMES`; it is decremented the same way as in SERVE.
  - On expiry, if either score == `WIN_SCORE` → OVER; otherwise → SERVE.
- OVER: `ball_en_o`=0, `ball_rst_o`=1.
  - `winner_o` is set from the score that reached `WIN_SCORE`.
  - `start_i` → SERVE. In the same edge: scores cleared, `winner_o`=00, `serve_dir_o`=1.
- Ignored inputs:
  - `start_i` in SERVE, PLAY or POINT.
  - Misses outside PLAY.
  - `frame_i` outside SERVE and POINT.
- Arithmetic:
  - Scores saturate at `WIN_SCORE` and never wrap.
  - Frame counter width is clog2(max(`SERVE_FRAMES`, `POINT_FRAMES`)+1).
  - A parameter value of 0 is treated as 1.
- Undefined `state_o` encodings recover to IDLE on the next edge.

## Timing
- All outputs are registered and change on the clock edge after the causing input cycle.
- Reset values (asserted asynchronously, immediately on `rst_n_i` low):
  - state IDLE; `ball_rst_o`=1; `ball_en_o`=0; `serve_dir_o`=1;
  - `score_l_o`, `score_r_o` = 0; `winner_o`=00; `leds_o`=0.
- Reset mid-rally aborts the match with no further score update.
- Deassertion of `rst_n_i` is synchronised internally (2-flop) before the FSM leaves reset.
- SERVE lasts exactly `SERVE_FRAMES` `frame_i` pulses; POINT lasts exactly `POINT_FRAMES`. A `frame_i` in the entry cycle is not counted.
- Miss to score update: 1 cycle. `ball_en_o` drops in that same edge.

## Configuration
- `PONG_LED_SCORE_EN` defined:
  - `leds_o[LEDS_W-1:LEDS_W/2]` = LSBs of `score_l`.
  - `leds_o[LEDS_W/2-1:0]` = LSBs of `score_r`.
- `PONG_LED_SCORE_EN` undefined:
  - `leds_o[0]`=PLAY, `[1]`=SERVE, `[2]`=POINT, `[3]`=OVER.
  - Remaining bits are 0.

## Test plan
Bench uses `SERVE_FRAMES`=3, `POINT_FRAMES`=2, `WIN_SCORE`=2.
- Start: `start_i` in IDLE, then 3 `frame_i` pulses → `state_o` 1, then `ball_en_o`=1 one cycle after the 3rd pulse. 2 pulses alone must leave `ball_en_o`=0.
- Right-wall miss: `miss_r_i` in PLAY → next cycle `score_l_o`=1, `ball_en_o`=0, `serve_dir_o`=1, `state_o`=3. After 2 frames `state_o`=1.
- Simultaneous misses: `miss_l_i`+`miss_r_i` in PLAY → scores unchanged, `state_o`=3.
- Win: left scores twice → after the POINT pause `state_o`=4, `winner_o`=01, `score_l_o`=2. Then `start_i` → scores 0, `winner_o`=00, `state_o`=1.
- Ignored inputs: misses during SERVE and `start_i` during PLAY → no score or state change.
- Async reset: pull `rst_n_i` low mid-PLAY with `score_r_o`=1 → all outputs at reset values before the next clock edge; FSM stays IDLE after release until `start_i`.
